// File: rtl/cy_control_reg_pulse_if.sv
`default_nettype none
// ============================================================================
// Module   : cy_control_reg_pulse_if
// Brief    : Write-side handshake bundle of the control register.
// Revision : 1.0  initial release
// ============================================================================
interface cy_control_reg_pulse_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       busy;
`ifdef CY_CTRL_REG_READBACK_EN
    logic [7:0] rd_data;

    modport master (output wr_en, output wr_data, input wr_ack, input busy, input rd_data);
    modport slave  (input wr_en, input wr_data, output wr_ack, output busy, output rd_data);
`else
    modport master (output wr_en, output wr_data, input wr_ack, input busy);
    modport slave  (input wr_en, input wr_data, output wr_ack, output busy);
`endif
endinterface
`default_nettype wire

// File: rtl/cy_control_reg_pulse.sv
`default_nettype none
// ============================================================================
// Module   : cy_control_reg_pulse
// Brief    : CPU-written control register with per-bit level/pulse modes.
//            Optional readback port enabled by CY_CTRL_REG_READBACK_EN.
// Revision : 1.0  initial release
// ============================================================================
module cy_control_reg_pulse #(
    parameter int         NUM_OUTPUTS = 8,
    parameter int         BUS_DISPLAY = 0,
    parameter logic [7:0] MODE_MASK   = 8'h00,
    parameter int         PULSE_WIDTH = 1,
    parameter logic [7:0] RESET_VALUE = 8'h00,
    parameter int         EXT_SYNC    = 0
) (
    input  wire logic             clock,
    input  wire logic             reset,
    cy_control_reg_pulse_if.slave bus_if,
    output logic                  control_0,
    output logic                  control_1,
    output logic                  control_2,
    output logic                  control_3,
    output logic                  control_4,
    output logic                  control_5,
    output logic                  control_6,
    output logic                  control_7,
    output logic [7:0]            control_bus
);

    localparam logic [7:0] c_live_mask  = 8'((9'd1 << NUM_OUTPUTS) - 9'd1);
    localparam logic [7:0] c_pulse_mask = MODE_MASK & c_live_mask;
    localparam logic [7:0] c_level_mask = ~MODE_MASK & c_live_mask;
    localparam logic [3:0] c_pulse_width = 4'(PULSE_WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] level_q, level_d;
    logic [7:0] pulse_q, pulse_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wr_ack_q, wr_ack_d;

    logic [7:0] w_pulse_wr;
    logic [7:0] w_reg_value;
    logic [7:0] w_out;
    logic       w_out_busy;

    assign w_pulse_wr  = bus_if.wr_data & c_pulse_mask;
    assign w_reg_value = level_q | pulse_q;

    always_comb begin
        level_d  = level_q;
        pulse_d  = pulse_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        wr_ack_d = bus_if.wr_en;
        if (bus_if.wr_en) begin
            level_d = bus_if.wr_data & c_level_mask;
        end
        // A new pulse write extends every active pulse bit; they all end together.
        if (bus_if.wr_en && (|w_pulse_wr)) begin
            pulse_d = pulse_q | w_pulse_wr;
            cnt_d   = c_pulse_width;
            state_d = PULSE;
        end else if (state_q == PULSE) begin
            if (cnt_q == 4'd1) begin
                pulse_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q  <= RESET_VALUE & c_level_mask;
            pulse_q  <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            wr_ack_q <= 1'b0;
        end else begin
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    // busy travels through the output stage so it stays aligned with the pulses.
    generate
        if (EXT_SYNC != 0) begin : g_sync
            logic [7:0] out_d, out_q;
            logic       busy_d, busy_q;
            assign out_d  = w_reg_value;
            assign busy_d = (state_q == PULSE);
            always_ff @(posedge clock) begin
                if (reset) begin
                    out_q  <= '0;
                    busy_q <= 1'b0;
                end else begin
                    out_q  <= out_d;
                    busy_q <= busy_d;
                end
            end
            assign w_out      = out_q;
            assign w_out_busy = busy_q;
        end else begin : g_nosync
            assign w_out      = w_reg_value;
            assign w_out_busy = (state_q == PULSE);
        end
    endgenerate

    generate
        if (BUS_DISPLAY != 0) begin : g_bus_view
            assign control_bus = w_out;
            assign {control_7, control_6, control_5, control_4,
                    control_3, control_2, control_1, control_0} = control_bus;
        end else begin : g_net_view
            assign {control_7, control_6, control_5, control_4,
                    control_3, control_2, control_1, control_0} = w_out;
            assign control_bus = {control_7, control_6, control_5, control_4,
                                  control_3, control_2, control_1, control_0};
        end
    endgenerate

    assign bus_if.wr_ack = wr_ack_q;
    assign bus_if.busy   = w_out_busy;
`ifdef CY_CTRL_REG_READBACK_EN
    assign bus_if.rd_data = w_reg_value;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cy_control_reg_pulse.sv
`default_nettype none
// ============================================================================
// Module   : tb_cy_control_reg_pulse
// Brief    : Six differently configured instances driven by one stimulus
//            stream and compared against a timestamp-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cy_control_reg_pulse;

    localparam int c_ndut = 6;

    function automatic int cfg_num(int i);
        return (i == 4) ? 4 : 8;
    endfunction

    function automatic logic [7:0] cfg_mode(int i);
        case (i)
            2:       return 8'h01;
            3:       return 8'h03;
            4:       return 8'h2A;
            5:       return 8'hF0;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int cfg_pw(int i);
        case (i)
            2:       return 3;
            3:       return 4;
            4:       return 2;
            5:       return 15;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] cfg_rv(int i);
        case (i)
            0:       return 8'hA5;
            2:       return 8'hFF;
            4:       return 8'hF5;
            5:       return 8'h0F;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int cfg_ext(int i);
        return (i == 1 || i == 5) ? 1 : 0;
    endfunction

    function automatic logic [7:0] cfg_live(int i);
        return 8'((1 << cfg_num(i)) - 1);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [8*c_ndut-1:0] bus_all;
    logic [8*c_ndut-1:0] nets_all;
    logic [8*c_ndut-1:0] rd_all;
    logic [c_ndut-1:0]   busy_all;
    logic [c_ndut-1:0]   ack_all;

    for (genvar g = 0; g < c_ndut; g++) begin : g_dut
        cy_control_reg_pulse_if u_if ();
        assign u_if.wr_en   = wr_en;
        assign u_if.wr_data = wr_data;
        assign busy_all[g]  = u_if.busy;
        assign ack_all[g]   = u_if.wr_ack;
`ifdef CY_CTRL_REG_READBACK_EN
        assign rd_all[g*8 +: 8] = u_if.rd_data;
`else
        assign rd_all[g*8 +: 8] = 8'h00;
`endif
        cy_control_reg_pulse #(
            .NUM_OUTPUTS (cfg_num(g)),
            .BUS_DISPLAY ((g == 5) ? 1 : 0),
            .MODE_MASK   (cfg_mode(g)),
            .PULSE_WIDTH (cfg_pw(g)),
            .RESET_VALUE (cfg_rv(g)),
            .EXT_SYNC    (cfg_ext(g))
        ) u_dut (
            .clock       (clk),
            .reset       (rst_s),
            .bus_if      (u_if.slave),
            .control_0   (nets_all[g*8 + 0]),
            .control_1   (nets_all[g*8 + 1]),
            .control_2   (nets_all[g*8 + 2]),
            .control_3   (nets_all[g*8 + 3]),
            .control_4   (nets_all[g*8 + 4]),
            .control_5   (nets_all[g*8 + 5]),
            .control_6   (nets_all[g*8 + 6]),
            .control_7   (nets_all[g*8 + 7]),
            .control_bus (bus_all[g*8 +: 8])
        );
    end

    // Reference model: a pulse is described by its bit set and the cycle
    // number at which it stops being visible.
    int         cyc = 0;
    logic [7:0] m_level [c_ndut];
    logic [7:0] m_bits  [c_ndut];
    int         m_end   [c_ndut];
    logic       m_busy  [c_ndut];
    logic [7:0] m_sync  [c_ndut];
    logic       m_busys [c_ndut];
    logic       m_ack   [c_ndut];

    initial begin
        for (int i = 0; i < c_ndut; i++) begin
            m_level[i] = 8'h00; m_bits[i] = 8'h00; m_end[i] = 0; m_busy[i] = 1'b0;
            m_sync[i]  = 8'h00; m_busys[i] = 1'b0; m_ack[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < c_ndut; i++) begin
            logic [7:0] pm, lm;
            pm = cfg_mode(i) & cfg_live(i);
            lm = ~cfg_mode(i) & cfg_live(i);
            if (rst_s) begin
                m_sync[i]  = 8'h00;
                m_busys[i] = 1'b0;
                m_level[i] = cfg_rv(i) & lm;
                m_bits[i]  = 8'h00;
                m_end[i]   = cyc;
                m_busy[i]  = 1'b0;
                m_ack[i]   = 1'b0;
            end else begin
                m_sync[i]  = m_level[i] | m_bits[i];
                m_busys[i] = m_busy[i];
                m_ack[i]   = wr_en;
                if (wr_en) begin
                    m_level[i] = wr_data & lm;
                    if ((wr_data & pm) != 8'h00) begin
                        if (!m_busy[i]) m_bits[i] = 8'h00;
                        m_bits[i] = m_bits[i] | (wr_data & pm);
                        m_end[i]  = cyc + cfg_pw(i);
                    end
                end
                m_busy[i] = (cyc < m_end[i]);
                if (!m_busy[i]) m_bits[i] = 8'h00;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < c_ndut; i++) begin
            logic [7:0] exp_v;
            logic       exp_b;
            exp_v = (cfg_ext(i) != 0) ? m_sync[i]  : (m_level[i] | m_bits[i]);
            exp_b = (cfg_ext(i) != 0) ? m_busys[i] : m_busy[i];
            check($sformatf("bus%0d", i),  32'(bus_all[i*8 +: 8]),  32'(exp_v));
            check($sformatf("nets%0d", i), 32'(nets_all[i*8 +: 8]), 32'(exp_v));
            check($sformatf("busy%0d", i), 32'(busy_all[i]),        32'(exp_b));
            check($sformatf("ack%0d", i),  32'(ack_all[i]),         32'(m_ack[i]));
`ifdef CY_CTRL_REG_READBACK_EN
            check($sformatf("rd%0d", i),   32'(rd_all[i*8 +: 8]),   32'(m_level[i] | m_bits[i]));
`endif
        end
    endtask

    task automatic step(input logic en, input logic [7:0] d, input logic r);
        wr_en   = en;
        wr_data = d;
        rst_s   = r;
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    int cnt0, cnt1, last0, last1;

    initial begin
        // Reset value, level bits masked by mode
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("rst_bus0",  32'(bus_all[7:0]), 32'h0A5);
        check("rst_busy0", 32'(busy_all[0]),  32'h0);
        check("rst_ack0",  32'(ack_all[0]),   32'h0);

        // Level write, plain and with the extra output stage
        step(1'b1, 8'h3C, 1'b0);
        check("lvl_bus0",  32'(bus_all[7:0]),  32'h03C);
        check("lvl_ack0",  32'(ack_all[0]),    32'h1);
        check("lvl_sync1", 32'(bus_all[15:8]), 32'h000);
        step(1'b0, 8'h00, 1'b0);
        check("lvl_sync1b", 32'(bus_all[15:8]), 32'h03C);
        check("lvl_ack0b",  32'(ack_all[0]),    32'h0);
        for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b0);

        // Isolated pulse, width 3
        cnt0 = 0;
        step(1'b1, 8'h01, 1'b0);
        if (bus_all[16]) cnt0++;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 8'h00, 1'b0);
            if (bus_all[16]) cnt0++;
        end
        check("pulse3_len", 32'(cnt0), 32'd3);
        check("pulse3_end", 32'(bus_all[16]), 32'h0);

        // Stretched pulse: bit0 then bit1 two cycles later, width 4
        cnt0 = 0; cnt1 = 0; last0 = -1; last1 = -1;
        for (int k = 0; k < 13; k++) begin
            if (k == 0)      step(1'b1, 8'h01, 1'b0);
            else if (k == 2) step(1'b1, 8'h02, 1'b0);
            else             step(1'b0, 8'h00, 1'b0);
            if (bus_all[24]) begin cnt0++; last0 = k; end
            if (bus_all[25]) begin cnt1++; last1 = k; end
        end
        check("stretch_b0",   32'(cnt0),  32'd6);
        check("stretch_b1",   32'(cnt1),  32'd4);
        check("stretch_fall", 32'(last1), 32'(last0));
        for (int k = 0; k < 16; k++) step(1'b0, 8'h00, 1'b0);

        // Bits beyond NumOutputs stay 0
        step(1'b1, 8'hFF, 1'b0);
        check("narrow_bus4", 32'(bus_all[39:32]),  32'h00F);
        check("narrow_hi4",  32'(nets_all[39:36]), 32'h0);
        for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b0);

        // Reset together with a write in the middle of a pulse
        step(1'b1, 8'h01, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b1);
        check("rstmid_bus2",  32'(bus_all[23:16]), 32'h0FE);
        check("rstmid_busy2", 32'(busy_all[2]),    32'h0);
        check("rstmid_ack2",  32'(ack_all[2]),     32'h0);
        step(1'b0, 8'h00, 1'b0);
        check("rstmid_noresume", 32'(bus_all[16]), 32'h0);

        // Randomised traffic including back-to-back writes and sporadic resets
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
